// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester arbiter/sequencer in front of a 128x8 single-port RAM
// Optional: define RAM_ARB_FIXED_PRIO_EN to make requester 0 win every tie.
module ram_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_rst,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              mem_rst_q;
    logic              last_grant_q, last_grant_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic pick1;
    logic accept;

    always_comb begin
        pick1 = 1'b0;
`ifdef RAM_ARB_FIXED_PRIO_EN
        pick1 = req1_valid & ~req0_valid;
`else
        // On a tie, hand the grant to whoever did not win last time.
        pick1 = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
`endif
    end

    assign accept     = (state_q == S_IDLE) && !mem_rst_q && (req0_valid || req1_valid);
    assign req0_ready = accept & ~pick1;
    assign req1_ready = accept &  pick1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    gnt_d        = pick1;
                    last_grant_d = pick1;
                    we_d         = pick1 ? req1_we    : req0_we;
                    addr_d       = pick1 ? req1_addr  : req0_addr;
                    wdata_d      = pick1 ? req1_wdata : req0_wdata;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            mem_rst_q    <= 1'b1;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            mem_rst_q    <= 1'b0;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign mem_rst    = mem_rst_q;
    assign mem_en     = (state_q == S_ACCESS);
    assign mem_we     = (state_q == S_ACCESS) & we_q;
    assign mem_addr   = addr_q;
    assign mem_in     = wdata_q;
    // The RAM registered its output at the ACCESS edge, so mem_out is already valid in RESP.
    assign rsp_rdata  = mem_out;
    assign rsp0_valid = (state_q == S_RESP) & ~gnt_q;
    assign rsp1_valid = (state_q == S_RESP) &  gnt_q;

endmodule
